seg7_digit_scan: RTL and testbench
==================================

// Module: seg7_digit_scan
// PURPOSE
//  Time-multiplexed scan driver for a multi-digit common-anode 7-segment display.
//  Holds a packed multi-digit hex/BCD value and presents one nibble per slot on bcd.
//  That nibble feeds the s7seg decoder directly downstream; the matching anode strobe goes out on an.
//  Value updates are double-buffered and applied only at frame boundaries, so no tearing.
// PARAMETERS
//  NUM_DIGITS  4      digits scanned; digit NUM_DIGITS-1 is most significant
//  DIV         50000  clk cycles per digit slot (dead time included); DIV > DEAD+1 required
//  DEAD        16     blanking cycles at the start of each slot (anodes all off); >= 1
//  LZB         1      1 = leading-zero blanking on, 0 = show all digits
// PORTS
//  clk          in   1             single system clock; all logic rising-edge
//  rst_n        in   1             synchronous reset, active-low
//  value_in     in   4*NUM_DIGITS  packed digits, nibble k = digit k
//  load         in   1             1-cycle strobe: capture value_in
//  bcd          out  4             current digit nibble to s7seg.bcd
//  an           out  NUM_DIGITS    anode enables, active-low, one-hot-low or all ones
//  blank        out  1             1 when an is all ones
//  frame_start  out  1             1-cycle pulse on the first cycle of the digit-0 slot
//  pending      out  1             loaded value waiting for the next frame boundary
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - cnt=0, idx=0, shadow=0, active=0
//   - an=all ones, bcd=4'h0, blank=1, frame_start=0, pending=0
//   - Mid-operation reset discards any pending load.
//  Slot timer:
//   - cnt runs 0..DIV-1.
//   - At cnt==DIV-1: cnt->0, idx->idx+1; idx wraps NUM_DIGITS-1 -> 0.
//  FSM (derived from cnt):
//   - DEAD: cnt<DEAD, an=all ones.
//   - ON:   cnt>=DEAD, an[idx]=0 unless digit idx is LZB-blanked.
//  Outputs:
//   - All outputs registered; one cycle of latency from cnt/idx state.
//   - bcd <= active[4*idx+:4] when cnt==0, so bcd is stable DEAD cycles before its anode goes low.
//  Load / double buffering:
//   - load: shadow<=value_in, pending<=1.
//   - Repeated loads within one frame: last one wins.
//  Frame boundary (cnt==DIV-1 && idx==NUM_DIGITS-1):
//   - If pending: active<=shadow, pending<=0.
//   - If load is high on this same cycle: active<=value_in directly, shadow<=value_in, pending stays 0.
//  frame_start: high exactly when registered state is cnt==0, idx==0.
//  Leading-zero blanking (LZB=1):
//   - Digit k>0 is blanked if active nibbles k..NUM_DIGITS-1 are all zero.
//   - Digit 0 is never blanked.
//   - A blanked digit keeps an high for its whole slot; blank=1; bcd still updates.
//  Nibbles 10..15 pass through unchanged; the decoder shows them as hex.
// STRUCTURE
//  - seg7_defs.vh: default NUM_DIGITS/DIV/DEAD, DEAD/ON state encodings, an all-off constant.
//  - Sub-module seg7_slot_timer: cnt/idx counters; emits slot_end and frame_end strobes.
//  - Top module holds shadow/active registers, LZB mask logic and output registers.
//  - s7seg is instantiated by the parent, not inside this block.
// TESTING  (bench uses NUM_DIGITS=4, DIV=8, DEAD=2)
//  1. rst_n=0 for 3 clks -> an=4'b1111, bcd=0, blank=1, pending=0.
//     Release -> first an=4'b1110 appears 3 clks after release.
//  2. load 16'h1234 mid-frame -> pending=1 until the boundary.
//     Next frame: an 1110/1101/1011/0111, each low 6 clks with 2 dead clks between.
//     bcd=4,3,2,1 respectively.
//  3. LZB=1, value 16'h0050 -> an[3], an[2] stay 1 all frame; digit1 bcd=5, digit0 bcd=0 lit.
//     Value 16'h0000 -> only an[0] ever goes low.
//  4. load 16'hABCD on the frame-boundary cycle -> pending never rises.
//     The following frame shows D,C,B,A.
//  5. Two loads (16'h1111, then 16'h2222) in one frame -> next frame shows 2222 only.
//  6. rst_n=0 for 1 clk during the ON phase of digit 2 with pending=1 -> next clk shows full reset values.
//     Scan restarts at idx 0.

Source files
------------

// File: rtl/seg7_digit_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: default sizing,
// slot phase encoding and the anode "off" level.
package seg7_digit_scan_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIV        = 50000;
    localparam int DEF_DEAD       = 16;
    localparam int DEF_LZB        = 1;

    // Common-anode display: a high anode line means the digit is dark.
    localparam logic ANODE_OFF = 1'b1;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_digit_scan_slot_timer.sv
// Slot timer: cnt counts clocks within a digit slot, idx selects the digit.
// Produces end-of-slot and end-of-frame strobes decoded from the current state.
module seg7_slot_timer #(
    parameter int DIV        = 8,
    parameter int NUM_DIGITS = 4,
    parameter int CW         = $clog2(DIV),
    parameter int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt_o,
    output logic [IW-1:0] idx_o,
    output logic          slot_end_o,
    output logic          frame_end_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    assign slot_end_o  = (cnt_q == CNT_LAST);
    assign frame_end_o = slot_end_o && (idx_q == IDX_LAST);
    assign cnt_o       = cnt_q;
    assign idx_o       = idx_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end_o) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_digit_scan.sv
// Multiplexed scan driver for a common-anode 7-segment display with
// frame-synchronous double-buffered value updates and leading-zero blanking.
module seg7_digit_scan
    import seg7_digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIV        = DEF_DIV,
    parameter int DEAD       = DEF_DEAD,
    parameter int LZB        = DEF_LZB
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    blank,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    slotEnd;
    logic                    frameEnd;
    slot_state_e             slotState;
    logic [NUM_DIGITS-1:0]   lzbMask;
    logic                    allZero;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    blank_q, blank_d;
    logic                    frame_start_q, frame_start_d;
    logic                    slot_start_q;

    seg7_slot_timer #(
        .DIV        (DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .CW         (CW),
        .IW         (IW)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_o       (cnt),
        .idx_o       (idx),
        .slot_end_o  (slotEnd),
        .frame_end_o (frameEnd)
    );

    // A digit is dark when it and every more significant nibble are zero.
    always_comb begin
        allZero = 1'b1;
        lzbMask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (active_q[4*k +: 4] == 4'h0);
            if (LZB != 0 && k != 0) begin
                lzbMask[k] = allZero;
            end
        end
    end

    // A load coinciding with the frame boundary bypasses the shadow copy.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frameEnd) begin
            pending_d = 1'b0;
            if (load) begin
                active_d = value_in;
                shadow_d = value_in;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
        end else if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        slotState     = (cnt < DEAD_C) ? ST_DEAD : ST_ON;
        an_d          = {NUM_DIGITS{ANODE_OFF}};
        bcd_d         = bcd_q;
        frame_start_d = frameEnd;
        if (slotState == ST_ON && !lzbMask[idx]) begin
            an_d[idx] = ~ANODE_OFF;
        end
        if (slot_start_q) begin
            bcd_d = active_q[{idx, 2'b00} +: 4];
        end
        blank_d = &an_d;
    end

    // slot_start_q mirrors cnt==0, including the first slot after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            an_q          <= {NUM_DIGITS{ANODE_OFF}};
            bcd_q         <= 4'h0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            slot_start_q  <= 1'b1;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            bcd_q         <= bcd_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            slot_start_q  <= slotEnd;
        end
    end

    assign an          = an_q;
    assign bcd         = bcd_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_digit_scan.sv
// Directed bench for seg7_digit_scan with a short slot (DIV=8, DEAD=2) so whole
// frames can be walked cycle by cycle.
module tb_seg7_digit_scan;

    localparam int NUM_DIGITS = 4;
    localparam int DIV        = 8;
    localparam int DEAD       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;
    logic        frame_start;
    logic        pending;

    int checkCount = 0;
    int errorCount = 0;

    seg7_digit_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV        (DIV),
        .DEAD       (DEAD),
        .LZB        (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .bcd         (bcd),
        .an          (an),
        .blank       (blank),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a negedge; pulses load for one clock and returns on the next negedge.
    task automatic applyStimulus(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic waitFrameStart();
        bit found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            found = frame_start;
        end
        checkOutput("frame_start_seen", 32'(found), 32'd1);
    endtask

    // Entered on the frame_start negedge; step t shows outputs registered from
    // slot state (t%8, t/8) and ends on the next frame_start negedge.
    task automatic checkFrame(input logic [15:0] v);
        logic [15:0] upper;
        logic [3:0]  expAn;
        logic [3:0]  nib;
        bit          dark;
        int          c;
        int          i;
        for (int t = 0; t < 4 * DIV; t++) begin
            @(negedge clk);
            c     = t % DIV;
            i     = t / DIV;
            upper = v >> (4 * i);
            nib   = upper[3:0];
            dark  = (i > 0) && (upper == 16'h0);
            expAn = 4'hF;
            if (c >= DEAD && !dark) expAn[i] = 1'b0;
            checkOutput($sformatf("an v%h d%0d c%0d", v, i, c), 32'(an), 32'(expAn));
            checkOutput($sformatf("bcd v%h d%0d c%0d", v, i, c), 32'(bcd), 32'(nib));
            checkOutput($sformatf("blank v%h d%0d c%0d", v, i, c), 32'(blank), 32'(expAn == 4'hF));
            checkOutput($sformatf("frame_start v%h t%0d", v, t), 32'(frame_start), 32'(t == 4 * DIV - 1));
            checkOutput($sformatf("pending v%h t%0d", v, t), 32'(pending), 32'd0);
        end
    endtask

    initial begin
        bit found;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;

        $display("[TB] test 1: reset and release");
        repeat (3) @(negedge clk);
        checkOutput("rst an", 32'(an), 32'hF);
        checkOutput("rst bcd", 32'(bcd), 32'h0);
        checkOutput("rst blank", 32'(blank), 32'd1);
        checkOutput("rst pending", 32'(pending), 32'd0);
        checkOutput("rst frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release+1 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("release+2 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("release+3 an", 32'(an), 32'hE);
        checkOutput("release+3 blank", 32'(blank), 32'd0);

        $display("[TB] test 2: mid-frame load 1234");
        applyStimulus(16'h1234);
        checkOutput("pending after load", 32'(pending), 32'd1);
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
            else checkOutput("pending held", 32'(pending), 32'd1);
        end
        checkOutput("frame_start_seen", 32'(found), 32'd1);
        checkOutput("pending at boundary", 32'(pending), 32'd0);
        checkFrame(16'h1234);

        $display("[TB] test 3: leading-zero blanking");
        applyStimulus(16'h0050);
        checkOutput("pending 0050", 32'(pending), 32'd1);
        waitFrameStart();
        checkFrame(16'h0050);
        applyStimulus(16'h0000);
        waitFrameStart();
        checkFrame(16'h0000);

        $display("[TB] test 4: load on frame boundary");
        repeat (4 * DIV - 1) @(negedge clk);
        value_in = 16'hABCD;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        checkOutput("boundary load frame_start", 32'(frame_start), 32'd1);
        checkOutput("boundary load pending", 32'(pending), 32'd0);
        checkFrame(16'hABCD);

        $display("[TB] test 5: last load wins");
        applyStimulus(16'h1111);
        @(negedge clk);
        applyStimulus(16'h2222);
        checkOutput("pending two loads", 32'(pending), 32'd1);
        waitFrameStart();
        checkFrame(16'h2222);

        $display("[TB] test 6: reset during digit 2 with pending load");
        applyStimulus(16'h3333);
        checkOutput("pending 3333", 32'(pending), 32'd1);
        repeat (2 * DIV + 3) @(negedge clk);
        checkOutput("digit2 on an", 32'(an), 32'hB);
        checkOutput("digit2 on bcd", 32'(bcd), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst an", 32'(an), 32'hF);
        checkOutput("midrst bcd", 32'(bcd), 32'h0);
        checkOutput("midrst blank", 32'(blank), 32'd1);
        checkOutput("midrst pending", 32'(pending), 32'd0);
        checkOutput("midrst frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        checkOutput("restart+1 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("restart+2 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("restart+3 an", 32'(an), 32'hE);
        checkOutput("restart+3 bcd", 32'(bcd), 32'h0);
        waitFrameStart();
        checkFrame(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
